// File: rtl/bus_pkg.sv
// Shared definitions for the tagged line request/response bus.
// Imported by the memory responder and the cache initiators.
package bus_pkg;
  localparam int TAG_W = 13;
  localparam int TAG_RW_BIT = 12;
  localparam int TAG_TYPE_MSB = 11;
  localparam int TAG_TYPE_LSB = 8;
  localparam logic [3:0] TYPE_MEMORY = 4'b0001;

  localparam int BEATS_PER_LINE = 8;
  localparam int BEAT_W = $clog2(BEATS_PER_LINE);
  localparam int LINE_OFS_W = 6;
  localparam logic [BEAT_W-1:0] BEAT_LAST =
    BEAT_W'(BEATS_PER_LINE - 1);

  typedef enum logic [2:0] {
    IDLE,
    DROP,
    RD_WAIT,
    RD_RESP,
    WR_DATA
  } bus_state_e;

  function automatic logic [3:0] tag_type(
    input logic [TAG_W-1:0] tag
  );
    return tag[TAG_TYPE_MSB:TAG_TYPE_LSB];
  endfunction
endpackage

// File: rtl/bus_mem_responder_if.sv
// Tagged request/response bus between a cache initiator
// and a memory-side responder.
interface bus_mem_responder_if #(
  parameter int DW = 64,
  parameter int TW = 13
);
  logic          bus_reqcyc;
  logic [DW-1:0] bus_req;
  logic [TW-1:0] bus_reqtag;
  logic          bus_reqack;
  logic          bus_respcyc;
  logic [DW-1:0] bus_resp;
  logic [TW-1:0] bus_resptag;
  logic          bus_respack;

  modport master (
    output bus_reqcyc,
    output bus_req,
    output bus_reqtag,
    output bus_respack,
    input  bus_reqack,
    input  bus_respcyc,
    input  bus_resp,
    input  bus_resptag
  );

  modport slave (
    input  bus_reqcyc,
    input  bus_req,
    input  bus_reqtag,
    input  bus_respack,
    output bus_reqack,
    output bus_respcyc,
    output bus_resp,
    output bus_resptag
  );
endinterface

// File: rtl/bus_line_store.sv
// Line array with beat-granular writes and a registered
// full-line read port.
module bus_line_store
  import bus_pkg::*;
#(
  parameter int DW = 64,
  parameter int LOG_NUM_LINES = 8
) (
  input  logic                        clk,
  input  logic                        we_i,
  input  logic [LOG_NUM_LINES-1:0]    widx_i,
  input  logic [BEAT_W-1:0]           wbeat_i,
  input  logic [DW-1:0]               wdata_i,
  input  logic [LOG_NUM_LINES-1:0]    ridx_i,
  output logic [BEATS_PER_LINE*DW-1:0] rdata_o
);
  localparam int LINE_W = BEATS_PER_LINE * DW;
  localparam int NUM_LINES = 2 ** LOG_NUM_LINES;

  logic [LINE_W-1:0] mem_q [NUM_LINES];
  logic [LINE_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i)
      mem_q[widx_i][wbeat_i*DW +: DW] <= wdata_i;
    rdata_q <= mem_q[ridx_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side responder: one line request at a time, 8-beat
// read bursts out of and 8-beat write bursts into a line store.
module bus_mem_responder
  import bus_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH = 13,
  parameter int LOG_NUM_LINES = 8,
  parameter int READ_LATENCY = 4
) (
  input  logic                clk,
  input  logic                reset,
  bus_mem_responder_if.slave  bus,
  output logic                busy
);
  localparam int DW = BUS_DATA_WIDTH;
  localparam int TW = BUS_TAG_WIDTH;
  localparam int LINE_W = BEATS_PER_LINE * DW;
  localparam int LAT_W = $clog2(READ_LATENCY + 1);
  localparam logic [LAT_W-1:0] LAT_LAST =
    LAT_W'(READ_LATENCY - 1);

  bus_state_e               state_q;
  logic [LOG_NUM_LINES-1:0] idx_q;
  logic [TW-1:0]            tag_q;
  logic [BEAT_W-1:0]        beat_q;
  logic [LAT_W-1:0]         lat_q;
  logic                     reqack_q;
  logic                     respcyc_q;
  logic                     busy_q;
  logic [DW-1:0]            resp_q;
  logic [TW-1:0]            resptag_q;

  logic                     req_new;
  logic                     wr_acc;
  logic                     resp_acc;
  logic [LOG_NUM_LINES-1:0] req_idx;
  logic [LOG_NUM_LINES-1:0] ridx;
  logic [BEAT_W-1:0]        beat_inc;
  logic [LINE_W-1:0]        line;

  assign req_idx = bus.bus_req[LINE_OFS_W +: LOG_NUM_LINES];
  assign beat_inc = beat_q + 1'b1;

  // reqack_q masks the ack cycle so a held reqcyc is not
  // taken twice
  assign req_new = (state_q == IDLE) &&
                   bus.bus_reqcyc && !reqack_q;
  assign wr_acc = (state_q == WR_DATA) &&
                  bus.bus_reqcyc && !reqack_q;
  assign resp_acc = respcyc_q && bus.bus_respack;

  // Read the incoming index while idle so the line is ready
  // even with a one-cycle latency
  assign ridx = (state_q == IDLE) ? req_idx : idx_q;

  bus_line_store #(
    .DW            (DW),
    .LOG_NUM_LINES (LOG_NUM_LINES)
  ) u_store (
    .clk     (clk),
    .we_i    (wr_acc),
    .widx_i  (idx_q),
    .wbeat_i (beat_q),
    .wdata_i (bus.bus_req),
    .ridx_i  (ridx),
    .rdata_o (line)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      tag_q     <= '0;
      beat_q    <= '0;
      lat_q     <= '0;
      reqack_q  <= 1'b0;
      respcyc_q <= 1'b0;
      busy_q    <= 1'b0;
      resp_q    <= '0;
      resptag_q <= '0;
    end else begin
      reqack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_new) begin
            idx_q    <= req_idx;
            tag_q    <= bus.bus_reqtag;
            reqack_q <= 1'b1;
            busy_q   <= 1'b1;
            lat_q    <= '0;
            beat_q   <= '0;
            if (tag_type(bus.bus_reqtag) != TYPE_MEMORY)
              state_q <= DROP;
            else if (bus.bus_reqtag[TAG_RW_BIT])
              state_q <= RD_WAIT;
            else
              state_q <= WR_DATA;
          end
        end
        DROP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        RD_WAIT: begin
          if (lat_q == LAT_LAST) begin
            lat_q     <= '0;
            beat_q    <= '0;
            state_q   <= RD_RESP;
            respcyc_q <= 1'b1;
            resptag_q <= tag_q;
            resp_q    <= line[0 +: DW];
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        RD_RESP: begin
          if (resp_acc) begin
            beat_q <= beat_inc;
            if (beat_q == BEAT_LAST) begin
              state_q   <= IDLE;
              busy_q    <= 1'b0;
              respcyc_q <= 1'b0;
              resp_q    <= '0;
              resptag_q <= '0;
            end else begin
              resp_q <= line[beat_inc*DW +: DW];
            end
          end
        end
        WR_DATA: begin
          if (wr_acc) begin
            reqack_q <= 1'b1;
            beat_q   <= beat_inc;
            if (beat_q == BEAT_LAST) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bus_reqack  = reqack_q;
  assign bus.bus_respcyc = respcyc_q;
  assign bus.bus_resp    = resp_q;
  assign bus.bus_resptag = resptag_q;
  assign busy            = busy_q;
endmodule
